update_element_par: RTL and testbench
=====================================

UPDATE_ELEMENT_PAR -- requirements
Module: update_element_par

Interface
REQ-001 SHALL have parameter I, default 10, residual vector length (rows).
REQ-002 SHALL have parameter N, default 8, signed two's-complement data width.
REQ-003 SHALL have parameter Q, default 3, fractional bits of every data word.
REQ-004 SHALL have parameter P, default 2, lanes per cycle; I mod P == 0, else elaboration error.
REQ-005 SHALL have ports clk input 1 (system clock) and rst_n input 1 (reset, asynchronous, active-low).
REQ-006 SHALL have ports start input 1 (begin update) and done output 1 (one-cycle completion pulse).
REQ-007 SHALL have ports busy output 1 (high from the cycle after start until done) and xhat_j input N (current coefficient).
REQ-008 SHALL have ports inv_norm2_j input N (1/||A_j||^2) and lambda input N (scaled threshold, unsigned).
REQ-009 SHALL have ports A_j input N x [0:I-1] (column j) and r_in input N x [0:I-1] (current residual).
REQ-010 SHALL have ports max_xj_in input N (running max |x|) and max_dxj_in input N (running max |dx|).
REQ-011 SHALL have ports r_out output N x [0:I-1], nxt_xhat_j output N, max_xj_out output N and max_dxj_out output N.

Function
REQ-012 SHALL use FSM states IDLE, CORR, UPD, RES, FIN; reset state IDLE.
REQ-013 SHALL, in IDLE on start=1, latch xhat_j, inv_norm2_j, lambda, max_xj_in and max_dxj_in, clear the accumulator and go to CORR; start in any other state is ignored.
REQ-014 SHALL require A_j and r_in to be held stable by the caller from start until done.
REQ-015 SHALL, in CORR, accumulate g += A_j[k]*r_in[k] for P indices per cycle over I/P cycles, in a full-precision accumulator of width 2N+clog2(I), then go to UPD.
REQ-016 SHALL, in UPD (1 cycle), compute z = sat_N(xhat_j + (((g>>>Q)*inv_norm2_j)>>>Q)), every shift arithmetic, truncating toward minus infinity.
REQ-017 SHALL compute nxt = sign(z)*max(|z|-lambda, 0), dx = sat_N(nxt - xhat_j), register nxt_xhat_j=nxt, max_xj_out=max(max_xj_in,|nxt|) and max_dxj_out=max(max_dxj_in,|dx|), with |-2^(N-1)| saturated to 2^(N-1)-1.
REQ-018 SHALL, in RES, write r_out[k] = sat_N(r_in[k] - ((A_j[k]*dx)>>>Q)) for P indices per cycle over I/P cycles, then go to FIN.
REQ-019 SHALL, in FIN, assert done for exactly one cycle and return to IDLE.
REQ-020 SHALL produce start-to-done latency of 2*(I/P)+2 cycles, done being high in cycle 2*(I/P)+2 after the start edge.
REQ-021 SHALL hold all outputs stable after done until the next accepted start.
REQ-022 SHALL keep busy=1 in CORR, UPD, RES and FIN and busy=0 in IDLE.

Reset
REQ-023 SHALL, on rst_n=0 in any state including mid-CORR or mid-RES, immediately force IDLE, done=0, busy=0, the accumulator, nxt_xhat_j, max outputs and all r_out to 0.
REQ-024 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with UPD_ELEM_ZERO_SKIP_EN defined and dx==0 in UPD, copy r_out = r_in in one cycle, skip RES, go to FIN, giving latency I/P+2.
REQ-026 SHALL, without UPD_ELEM_ZERO_SKIP_EN, always traverse RES, latency fixed per REQ-020.

Structure
REQ-027 SHALL place the state enum type, accumulator-width and lane-count helper constants, and the saturation-limit constants in shared package upd_elem_pkg.
REQ-028 SHALL implement the soft threshold of REQ-017 in combinational sub-module soft_threshold (ports z, lambda, nxt).

Verification (I=10,N=8,Q=3,P=2; 1.0=8'h08)
REQ-029 SHALL check reset: rst_n=0 -> all outputs 0, done=0, busy=0; start in the first cycle after release is accepted.
REQ-030 SHALL check nominal: A_j=all 8'h08, r_in=all 8'h08, xhat_j=0, inv=8'h08, lambda=8'h10 -> nxt_xhat_j=8'h40, r_out=all 8'hC8, max outputs 8'h40, done at cycle 12.
REQ-031 SHALL check zero update: same stimulus with lambda=8'h7F -> nxt=0, r_out=r_in, done at cycle 12 (7 with UPD_ELEM_ZERO_SKIP_EN).
REQ-032 SHALL check saturation: r_in=all 8'h80, A_j=all 8'hF8, lambda=8'h10 -> z clamps to 8'h7F, nxt=8'h6F, r_out=all 8'hEF, max_xj_out=8'h6F.
REQ-033 SHALL check that max_xj_in=8'h7F persists to max_xj_out=8'h7F, and that start pulsed while busy changes neither latency nor result.
REQ-034 SHALL check that rst_n=0 during RES clears r_out to 0 with no done, and that a following start completes normally.

Source files
------------

// File: rtl/upd_elem_pkg.sv
// Shared types and sizing helpers for the parallel coordinate-update element.
// Consumed by update_element_par (build option UPD_ELEM_ZERO_SKIP_EN lives there).
package upd_elem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CORR = 3'd1,
    UPD  = 3'd2,
    RES  = 3'd3,
    FIN  = 3'd4
  } state_e;

  // Full-precision width of a sum of i products of two n-bit words.
  function automatic int acc_width(input int i, input int n);
    return 2 * n + $clog2(i);
  endfunction

  function automatic int lane_cycles(input int i, input int p);
    return i / p;
  endfunction

  // Counter width for i/p steps, never narrower than one bit.
  function automatic int idx_width(input int i, input int p);
    return (i / p > 1) ? $clog2(i / p) : 1;
  endfunction

  function automatic longint sat_max(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

endpackage

// File: rtl/soft_threshold.sv
// Combinational soft threshold: nxt = sign(z) * max(|z| - lambda, 0).
// lambda is unsigned; |z| is formed one bit wider so z = -2^(N-1) is exact.
module soft_threshold #(
  parameter int N = 8
) (
  input  logic signed [N-1:0] z,
  input  logic        [N-1:0] lambda,
  output logic signed [N-1:0] nxt
);

  logic [N:0] mag;
  logic [N:0] shrunk;
  logic [N:0] res;

  always_comb begin
    mag    = z[N-1] ? (~{1'b1, z}) + (N+1)'(1) : {1'b0, z};
    shrunk = (mag > {1'b0, lambda}) ? mag - {1'b0, lambda} : '0;
    res    = z[N-1] ? (~shrunk) + (N+1)'(1) : shrunk;
    nxt    = res[N-1:0];
  end

endmodule

// File: rtl/update_element_par.sv
// One coordinate-descent update of coefficient j with P-lane correlation and residual update.
// Define UPD_ELEM_ZERO_SKIP_EN to bypass the residual pass when the step dx is zero.
module update_element_par
  import upd_elem_pkg::*;
#(
  parameter int I = 10,
  parameter int N = 8,
  parameter int Q = 3,
  parameter int P = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                done,
  output logic                busy,
  input  logic signed [N-1:0] xhat_j,
  input  logic signed [N-1:0] inv_norm2_j,
  input  logic        [N-1:0] lambda,
  input  logic signed [N-1:0] A_j [0:I-1],
  input  logic signed [N-1:0] r_in [0:I-1],
  input  logic signed [N-1:0] max_xj_in,
  input  logic signed [N-1:0] max_dxj_in,
  output logic signed [N-1:0] r_out [0:I-1],
  output logic signed [N-1:0] nxt_xhat_j,
  output logic signed [N-1:0] max_xj_out,
  output logic signed [N-1:0] max_dxj_out
);

  localparam int ACC_W = acc_width(I, N);
  localparam int CYC   = lane_cycles(I, P);
  localparam int IDX_W = idx_width(I, P);
  localparam int KW    = idx_width(I, 1);
  localparam int WZ    = ACC_W + N + 1;
  localparam logic signed [WZ-1:0] SAT_HI = WZ'(sat_max(N));
  localparam logic signed [WZ-1:0] SAT_LO = WZ'(sat_min(N));
  localparam logic signed [N-1:0]  MAX_N  = SAT_HI[N-1:0];
  localparam logic signed [N-1:0]  MIN_N  = SAT_LO[N-1:0];

  if (I % P != 0) begin : g_bad_lanes
    $error("update_element_par: I must be a multiple of P");
  end

  function automatic logic signed [N-1:0] sat_n(input logic signed [WZ-1:0] v);
    if (v > SAT_HI)      return MAX_N;
    else if (v < SAT_LO) return MIN_N;
    else                 return v[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] abs_sat(input logic signed [N-1:0] v);
    if (v == MIN_N)   return MAX_N;
    else if (v[N-1])  return -v;
    else              return v;
  endfunction

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [N-1:0]     xhat_q, xhat_d;
  logic signed [N-1:0]     inv_q, inv_d;
  logic        [N-1:0]     lam_q, lam_d;
  logic signed [N-1:0]     mx_in_q, mx_in_d;
  logic signed [N-1:0]     mdx_in_q, mdx_in_d;
  logic signed [N-1:0]     dx_q, dx_d;
  logic signed [N-1:0]     nxt_q, nxt_d;
  logic signed [N-1:0]     mx_out_q, mx_out_d;
  logic signed [N-1:0]     mdx_out_q, mdx_out_d;
  logic signed [N-1:0]     r_q [0:I-1];
  logic signed [N-1:0]     r_d [0:I-1];

  logic signed [ACC_W+N-1:0] gm;
  logic signed [WZ-1:0]      z_w;
  logic signed [N-1:0]       z_val;
  logic signed [N-1:0]       nxt_val;
  logic signed [WZ-1:0]      dx_w;
  logic signed [N-1:0]       dx_val;
  logic signed [N-1:0]       abs_nxt;
  logic signed [N-1:0]       abs_dx;

  logic [KW-1:0]         lane_k    [P];
  logic signed [2*N-1:0] corr_prod [P];
  logic signed [2*N-1:0] res_prod  [P];
  logic signed [N-1:0]   res_val   [P];

  // Lane gi of step idx handles column element idx*P + gi in both passes.
  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    assign lane_k[gi]    = KW'(idx_q) * KW'(P) + KW'(gi);
    assign corr_prod[gi] = (2*N)'(A_j[lane_k[gi]]) * (2*N)'(r_in[lane_k[gi]]);
    assign res_prod[gi]  = (2*N)'(A_j[lane_k[gi]]) * (2*N)'(dx_q);
    assign res_val[gi]   = sat_n(WZ'(r_in[lane_k[gi]]) - WZ'(res_prod[gi] >>> Q));
  end

  always_comb begin
    gm    = (ACC_W+N)'(acc_q >>> Q) * (ACC_W+N)'(inv_q);
    z_w   = WZ'(xhat_q) + WZ'(gm >>> Q);
    z_val = sat_n(z_w);
  end

  soft_threshold #(.N(N)) u_soft_threshold (
    .z      (z_val),
    .lambda (lam_q),
    .nxt    (nxt_val)
  );

  always_comb begin
    dx_w    = WZ'(nxt_val) - WZ'(xhat_q);
    dx_val  = sat_n(dx_w);
    abs_nxt = abs_sat(nxt_val);
    abs_dx  = abs_sat(dx_val);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    xhat_d    = xhat_q;
    inv_d     = inv_q;
    lam_d     = lam_q;
    mx_in_d   = mx_in_q;
    mdx_in_d  = mdx_in_q;
    dx_d      = dx_q;
    nxt_d     = nxt_q;
    mx_out_d  = mx_out_q;
    mdx_out_d = mdx_out_q;
    r_d       = r_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          xhat_d   = xhat_j;
          inv_d    = inv_norm2_j;
          lam_d    = lambda;
          mx_in_d  = max_xj_in;
          mdx_in_d = max_dxj_in;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = CORR;
        end
      end
      CORR: begin
        for (int p = 0; p < P; p++) begin
          acc_d = acc_d + ACC_W'(corr_prod[p]);
        end
        if (idx_q == IDX_W'(CYC - 1)) begin
          idx_d   = '0;
          state_d = UPD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      UPD: begin
        nxt_d     = nxt_val;
        dx_d      = dx_val;
        mx_out_d  = (abs_nxt > mx_in_q) ? abs_nxt : mx_in_q;
        mdx_out_d = (abs_dx > mdx_in_q) ? abs_dx : mdx_in_q;
        idx_d     = '0;
`ifdef UPD_ELEM_ZERO_SKIP_EN
        if (dx_val == '0) begin
          r_d     = r_in;
          state_d = FIN;
        end else begin
          state_d = RES;
        end
`else
        state_d = RES;
`endif
      end
      RES: begin
        for (int p = 0; p < P; p++) begin
          r_d[lane_k[p]] = res_val[p];
        end
        if (idx_q == IDX_W'(CYC - 1)) begin
          idx_d   = '0;
          state_d = FIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      xhat_q    <= '0;
      inv_q     <= '0;
      lam_q     <= '0;
      mx_in_q   <= '0;
      mdx_in_q  <= '0;
      dx_q      <= '0;
      nxt_q     <= '0;
      mx_out_q  <= '0;
      mdx_out_q <= '0;
      for (int k = 0; k < I; k++) r_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      xhat_q    <= xhat_d;
      inv_q     <= inv_d;
      lam_q     <= lam_d;
      mx_in_q   <= mx_in_d;
      mdx_in_q  <= mdx_in_d;
      dx_q      <= dx_d;
      nxt_q     <= nxt_d;
      mx_out_q  <= mx_out_d;
      mdx_out_q <= mdx_out_d;
      r_q       <= r_d;
    end
  end

  assign done        = (state_q == FIN);
  assign busy        = (state_q != IDLE);
  assign r_out       = r_q;
  assign nxt_xhat_j  = nxt_q;
  assign max_xj_out  = mx_out_q;
  assign max_dxj_out = mdx_out_q;

endmodule

// File: tb/tb_update_element_par.sv
// Bench for update_element_par: spec vector table, reset corner cases, random ops vs. arithmetic model.
// Cycle 1 is the cycle that begins at the edge sampling start; done is expected in cycle 2*(I/P)+2.
module tb_update_element_par;

  localparam int I = 10;
  localparam int N = 8;
  localparam int Q = 3;
  localparam int P = 2;
  localparam int FULL_LAT = 2 * (I / P) + 2;
  localparam int SKIP_LAT = (I / P) + 2;
`ifdef UPD_ELEM_ZERO_SKIP_EN
  localparam int ZERO_LAT = SKIP_LAT;
`else
  localparam int ZERO_LAT = FULL_LAT;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                done;
  logic                busy;
  logic signed [N-1:0] xh_v;
  logic signed [N-1:0] inv_v;
  logic        [N-1:0] lam_v;
  logic signed [N-1:0] a_v [0:I-1];
  logic signed [N-1:0] r_v [0:I-1];
  logic signed [N-1:0] mx_v;
  logic signed [N-1:0] mdx_v;
  logic signed [N-1:0] r_out_w [0:I-1];
  logic signed [N-1:0] nxt_w;
  logic signed [N-1:0] mx_out_w;
  logic signed [N-1:0] mdx_out_w;

  int n_vec = 0;
  int n_err = 0;
  int e_r [0:I-1];

  always #5 clk = ~clk;

  update_element_par #(.I(I), .N(N), .Q(Q), .P(P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .xhat_j      (xh_v),
    .inv_norm2_j (inv_v),
    .lambda      (lam_v),
    .A_j         (a_v),
    .r_in        (r_v),
    .max_xj_in   (mx_v),
    .max_dxj_in  (mdx_v),
    .r_out       (r_out_w),
    .nxt_xhat_j  (nxt_w),
    .max_xj_out  (mx_out_w),
    .max_dxj_out (mdx_out_w)
  );

  typedef struct {
    logic [7:0] a, r, xh, inv, lam, mx, mdx;
    int         restart_at;
    logic [7:0] e_nxt, e_r, e_mx, e_mdx;
    int         e_lat;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %02h, want %02h", nm, act, exp_v);
    end
  endtask

  function automatic longint satl(input longint v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int abssat(input longint v);
    longint m;
    m = (v < 0) ? -v : v;
    return int'(satl(m));
  endfunction

  // Straight arithmetic from the update rules, applied to the currently driven inputs.
  task automatic model(output int e_nxt, output int e_mx, output int e_mdx, output int e_dx);
    longint g, z, m, d;
    g = 0;
    for (int k = 0; k < I; k++) g += longint'(a_v[k]) * longint'(r_v[k]);
    z = satl(longint'(xh_v) + (((g >>> Q) * longint'(inv_v)) >>> Q));
    m = ((z < 0) ? -z : z) - longint'(lam_v);
    if (m < 0) m = 0;
    e_nxt = int'((z < 0) ? -m : m);
    d     = satl(longint'(e_nxt) - longint'(xh_v));
    e_dx  = int'(d);
    e_mx  = (abssat(e_nxt) > int'(mx_v)) ? abssat(e_nxt) : int'(mx_v);
    e_mdx = (abssat(d) > int'(mdx_v)) ? abssat(d) : int'(mdx_v);
    for (int k = 0; k < I; k++)
      e_r[k] = int'(satl(longint'(r_v[k]) - ((longint'(a_v[k]) * d) >>> Q)));
  endtask

  // Starts at a negedge, returns at a negedge two cycles after done.
  task automatic run_op(input string tag, input int restart_at, output int lat);
    int c;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_c1"}, int'(busy), 1);
    c = 1;
    while (!done && c < 40) begin
      start = (c == restart_at);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    lat = done ? c : -1;
    chk({tag, "_busy_at_done"}, int'(busy), 1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    @(negedge clk);
    chk({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < I; k++) begin
      a_v[k] = v.a;
      r_v[k] = v.r;
    end
    xh_v  = v.xh;
    inv_v = v.inv;
    lam_v = v.lam;
    mx_v  = v.mx;
    mdx_v = v.mdx;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int lat);
    chk({tag, "_latency"}, lat, v.e_lat);
    chk8({tag, "_nxt"}, nxt_w, v.e_nxt);
    chk8({tag, "_max_x"}, mx_out_w, v.e_mx);
    chk8({tag, "_max_dx"}, mdx_out_w, v.e_mdx);
    for (int k = 0; k < I; k++)
      chk8($sformatf("%s_r_out%0d", tag, k), r_out_w[k], v.e_r);
  endtask

  initial begin
    int lat, e_nxt, e_mx, e_mdx, e_dx, e_lat, rs;

    //         a      r      xh     inv    lam    mx     mdx   rs  nxt    r      mx     mdx    lat
    tbl[0] = '{8'h08, 8'h08, 8'h00, 8'h08, 8'h10, 8'h00, 8'h00, 0, 8'h40, 8'hC8, 8'h40, 8'h40, FULL_LAT};
    tbl[1] = '{8'h08, 8'h08, 8'h00, 8'h08, 8'h7F, 8'h00, 8'h00, 0, 8'h00, 8'h08, 8'h00, 8'h00, ZERO_LAT};
    tbl[2] = '{8'hF8, 8'h80, 8'h00, 8'h08, 8'h10, 8'h00, 8'h00, 0, 8'h6F, 8'hEF, 8'h6F, 8'h6F, FULL_LAT};
    tbl[3] = '{8'h08, 8'h08, 8'h00, 8'h08, 8'h10, 8'h7F, 8'h7F, 3, 8'h40, 8'hC8, 8'h7F, 8'h7F, FULL_LAT};
    tbl[4] = '{8'h08, 8'hF8, 8'h20, 8'h08, 8'h08, 8'h00, 8'h00, 5, 8'hD8, 8'h40, 8'h28, 8'h48, FULL_LAT};

    rst_n = 1'b0;
    start = 1'b0;
    load_vec(tbl[1]);
    repeat (3) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk8("rst_nxt", nxt_w, 8'h00);
    chk8("rst_max_x", mx_out_w, 8'h00);
    chk8("rst_max_dx", mdx_out_w, 8'h00);
    for (int k = 0; k < I; k++) chk8($sformatf("rst_r_out%0d", k), r_out_w[k], 8'h00);

    // Release and start on the same negedge: the first rising edge must accept it.
    rst_n = 1'b1;
    for (int v = 0; v < 5; v++) begin
      load_vec(tbl[v]);
      run_op($sformatf("vec%0d", v), tbl[v].restart_at, lat);
      check_vec($sformatf("vec%0d", v), tbl[v], lat);
      $display("vec%0d: nxt=%02h r0=%02h mx=%02h mdx=%02h latency=%0d", v, nxt_w, r_out_w[0], mx_out_w, mdx_out_w, lat);
    end

    // Reset asserted mid-way through the residual pass.
    load_vec(tbl[0]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midres_busy", int'(busy), 0);
    chk("midres_done", int'(done), 0);
    chk8("midres_nxt", nxt_w, 8'h00);
    chk8("midres_max_x", mx_out_w, 8'h00);
    for (int k = 0; k < I; k++) chk8($sformatf("midres_r_out%0d", k), r_out_w[k], 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midres_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    run_op("after_rst", 0, lat);
    check_vec("after_rst", tbl[0], lat);
    $display("after_rst: nxt=%02h r0=%02h latency=%0d", nxt_w, r_out_w[0], lat);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < I; k++) begin
        a_v[k] = N'($urandom);
        r_v[k] = N'($urandom);
      end
      xh_v  = N'($urandom);
      inv_v = N'($urandom_range(0, 16));
      lam_v = N'($urandom_range(0, 64));
      mx_v  = N'($urandom_range(0, 127));
      mdx_v = N'($urandom_range(0, 127));
      if (t % 5 == 0) lam_v = 8'hFF;
      rs = (t % 3 == 0) ? int'($urandom_range(2, 10)) : 0;
      model(e_nxt, e_mx, e_mdx, e_dx);
`ifdef UPD_ELEM_ZERO_SKIP_EN
      e_lat = (e_dx == 0) ? SKIP_LAT : FULL_LAT;
`else
      e_lat = FULL_LAT;
`endif
      run_op($sformatf("rnd%0d", t), rs, lat);
      chk($sformatf("rnd%0d_latency", t), lat, e_lat);
      chk8($sformatf("rnd%0d_nxt", t), nxt_w, 8'(e_nxt));
      chk8($sformatf("rnd%0d_max_x", t), mx_out_w, 8'(e_mx));
      chk8($sformatf("rnd%0d_max_dx", t), mdx_out_w, 8'(e_mdx));
      for (int k = 0; k < I; k++)
        chk8($sformatf("rnd%0d_r_out%0d", t, k), r_out_w[k], 8'(e_r[k]));
      $display("rnd%0d: xh=%02h nxt=%02h dx=%0d latency=%0d", t, xh_v, nxt_w, e_dx, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
